// File: rtl/exp_accel_pkg.sv
// exp_accel_pkg: accelerator register map and initiator state encoding.
package exp_accel_pkg;
  localparam int REG_CTRL = 0;
  localparam int REG_BASE = 1;
  localparam int REG_EXP = 2;
  localparam int REG_STATUS = 3;
  localparam int REG_RESULT = 4;
  localparam int STATUS_DONE_BIT = 0;
  typedef enum logic [2:0] {IDLE, WR_BASE, WR_EXP, WR_GO, RD_STAT, RD_RES, RSP} initiator_state_t;
  function automatic logic is_xfer_state(initiator_state_t s);
    return s inside {WR_BASE, WR_EXP, WR_GO, RD_STAT, RD_RES};
  endfunction
endpackage

// File: rtl/avmm_single_xfer.sv
// avmm_single_xfer: one Avalon-MM read or write, held until the slave drops waitrequest.
module avmm_single_xfer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              is_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_read,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic              done,
  output logic [DATA_W-1:0] rdata
);
  logic free;
  assign done = (avm_read || avm_write) && !avm_waitrequest;
  assign free = !(avm_read || avm_write) || done;
  assign rdata = avm_readdata;
  // a new transfer may be loaded on the same edge the current one completes
  always_ff @(posedge clk) begin
    if (reset) begin
      avm_address <= '0;
      avm_writedata <= '0;
      avm_write <= 1'b0;
      avm_read <= 1'b0;
    end else if (free) begin
      avm_write <= go && is_write;
      avm_read <= go && !is_write;
      if (go) begin
        avm_address <= addr;
        avm_writedata <= wdata;
      end
    end
  end
endmodule

// File: rtl/exp_avmm_initiator.sv
// exp_avmm_initiator: sequences BASE/EXP/GO writes, STATUS polling and RESULT read on the accelerator.
module exp_avmm_initiator import exp_accel_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int POLL_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_base,
  input  logic [DATA_W-1:0] cmd_exp,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_read,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);
  localparam int CW = $clog2(POLL_LIMIT + 1);
  initiator_state_t state, next_state;
  logic [DATA_W-1:0] base_q, exp_q, rdata, wdata;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0] poll_cnt;
  logic done, go, is_write, stat_done, poll_last;
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == RSP;
  assign stat_done = rdata[STATUS_DONE_BIT];
  assign poll_last = (poll_cnt + CW'(1)) == CW'(POLL_LIMIT);
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = cmd_valid ? WR_BASE : IDLE;
      WR_BASE: next_state = done ? WR_EXP : WR_BASE;
      WR_EXP:  next_state = done ? WR_GO : WR_EXP;
      WR_GO:   next_state = done ? RD_STAT : WR_GO;
      RD_STAT: next_state = !done ? RD_STAT : stat_done ? RD_RES : poll_last ? RSP : RD_STAT;
      RD_RES:  next_state = done ? RSP : RD_RES;
      RSP:     next_state = rsp_ready ? IDLE : RSP;
      default: next_state = IDLE;
    endcase
  end
  // the transfer for next_state is presented so it loads on the edge the current one completes
  always_comb begin
    go = is_xfer_state(state) && is_xfer_state(next_state);
    is_write = next_state inside {WR_BASE, WR_EXP, WR_GO};
    addr = next_state == WR_BASE ? ADDR_W'(REG_BASE) :
           next_state == WR_EXP  ? ADDR_W'(REG_EXP) :
           next_state == RD_STAT ? ADDR_W'(REG_STATUS) :
           next_state == RD_RES  ? ADDR_W'(REG_RESULT) : ADDR_W'(REG_CTRL);
    wdata = next_state == WR_BASE ? base_q :
            next_state == WR_EXP  ? exp_q :
            next_state == WR_GO   ? DATA_W'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      base_q <= '0;
      exp_q <= '0;
      poll_cnt <= '0;
      rsp_result <= '0;
      rsp_error <= 1'b0;
    end else begin
      state <= next_state;
      if (cmd_valid && cmd_ready) begin
        base_q <= cmd_base;
        exp_q <= cmd_exp;
        poll_cnt <= '0;
        rsp_error <= 1'b0;
      end
      if (state == RD_STAT && done && !stat_done) poll_cnt <= poll_cnt + CW'(1);
      if (state == RD_STAT && done && !stat_done && poll_last) begin
        rsp_result <= '0;
        rsp_error <= 1'b1;
      end
      if (state == RD_RES && done) begin
        rsp_result <= rdata;
        rsp_error <= 1'b0;
      end
    end
  end
  avmm_single_xfer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_xfer (
    .clk(clk),
    .reset(reset),
    .go(go),
    .is_write(is_write),
    .addr(addr),
    .wdata(wdata),
    .avm_address(avm_address),
    .avm_write(avm_write),
    .avm_writedata(avm_writedata),
    .avm_read(avm_read),
    .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .done(done),
    .rdata(rdata)
  );
endmodule
